// File: rtl/wb_gpio_ctrl_pkg.sv
// rtl/wb_gpio_ctrl_pkg.sv - register offsets, ack states and byte-lane helper for the GPIO slave
package wb_gpio_ctrl_pkg;

  localparam int REG_SEL_W = 3;

  localparam logic [REG_SEL_W-1:0] REG_OUT   = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_DIR   = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_IN    = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_IEN   = 3'd3;
  localparam logic [REG_SEL_W-1:0] REG_ISTAT = 3'd4;
  localparam logic [REG_SEL_W-1:0] REG_EDGE  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_ctrl_if.sv
// rtl/wb_gpio_ctrl_if.sv - Wishbone classic bus bundle between the CPU side and the GPIO slave
interface wb_gpio_ctrl_if;
  import wb_gpio_ctrl_pkg::*;

  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_gpio_ctrl_gpio_sync_edge.sv
// rtl/wb_gpio_ctrl_gpio_sync_edge.sv - pad synchroniser with history flop and rise/fall detect
module gpio_sync_edge
  import wb_gpio_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= pin;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign level = stage_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// rtl/wb_gpio_ctrl.sv - Wishbone classic GPIO slave: direction, output, input, edge status, irq
module wb_gpio_ctrl
  import wb_gpio_ctrl_pkg::*;
#(
  parameter int NGPIO    = 8,
  parameter int SYNC_STG = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_gpio_ctrl_if.slave    wb,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe_o,
  output logic             irq_o
);

  ack_state_t state, state_next;

  logic                 req, wr;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [31:0]          lane_m, rd_word, dat_q;
  logic [NGPIO-1:0]     m, wdat;
  logic [NGPIO-1:0]     out_r, dir_r, ien_r, istat_r, edge_sel_r;
  logic [NGPIO-1:0]     in_lvl, rise, fall, ev, w1c, istat_next, ien_next;
  logic                 irq_r;
  logic                 unused_bits;

  gpio_sync_edge #(
    .WIDTH  (NGPIO),
    .STAGES (SYNC_STG)
  ) u_sync_edge (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .pin   (gpio_i),
    .level (in_lvl),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A request is only taken while idle, which forces one dead cycle between acks.
  assign req     = (state == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign wr      = req && wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[4:2];
  assign lane_m  = lane_mask(wb.wb_sel_i);
  assign m       = lane_m[NGPIO-1:0];
  assign wdat    = wb.wb_dat_i[NGPIO-1:0] & m;

  assign ev         = (edge_sel_r & rise) | (~edge_sel_r & fall);
  assign w1c        = (wr && reg_sel == REG_ISTAT) ? wdat : '0;
  assign istat_next = (istat_r & ~w1c) | ev;
  assign ien_next   = (wr && reg_sel == REG_IEN) ? ((ien_r & ~m) | wdat) : ien_r;

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_OUT:   rd_word[NGPIO-1:0] = out_r;
      REG_DIR:   rd_word[NGPIO-1:0] = dir_r;
      REG_IN:    rd_word[NGPIO-1:0] = in_lvl;
      REG_IEN:   rd_word[NGPIO-1:0] = ien_r;
      REG_ISTAT: rd_word[NGPIO-1:0] = istat_r;
      REG_EDGE:  rd_word[NGPIO-1:0] = edge_sel_r;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      dat_q      <= '0;
      out_r      <= '0;
      dir_r      <= '0;
      ien_r      <= '0;
      istat_r    <= '0;
      edge_sel_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      state   <= state_next;
      dat_q   <= (req && !wb.wb_we_i) ? rd_word : '0;
      ien_r   <= ien_next;
      istat_r <= istat_next;
      irq_r   <= |(istat_next & ien_next);
      if (wr) begin
        case (reg_sel)
          REG_OUT:  out_r      <= (out_r & ~m) | wdat;
          REG_DIR:  dir_r      <= (dir_r & ~m) | wdat;
          REG_EDGE: edge_sel_r <= (edge_sel_r & ~m) | wdat;
          default:  ;
        endcase
      end
    end
  end

  assign wb.wb_ack_o = (state == ST_ACK);
  assign wb.wb_dat_o = dat_q;
  assign gpio_o      = out_r;
  assign gpio_oe_o   = dir_r;
  assign irq_o       = irq_r;

  assign unused_bits = &{1'b0, wb.wb_adr_i[1:0], wb.wb_dat_i, lane_m};

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// tb/tb_wb_gpio_ctrl.sv - self-checking bench for wb_gpio_ctrl with a register-level model
module tb_wb_gpio_ctrl;

  localparam int NGPIO    = 8;
  localparam int SYNC_STG = 2;
  localparam logic [31:0] NMASK = (NGPIO == 32) ? 32'hFFFF_FFFF : ((32'd1 << NGPIO) - 32'd1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NGPIO-1:0] gpio_in = '0;
  logic [NGPIO-1:0] gpio_out, gpio_oe;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  wb_gpio_ctrl_if bus ();

  wb_gpio_ctrl #(
    .NGPIO    (NGPIO),
    .SYNC_STG (SYNC_STG)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file indexed by word offset: 0 OUT, 1 DIR, 3 IEN, 4 ISTAT, 5 EDGE.
  logic [31:0] m_reg [8];
  logic [31:0] m_in, m_prev, m_dat;
  logic        m_ack, m_irq;
  logic [31:0] pad_hist [$];

  always @(posedge clk) begin : model
    logic [31:0] ev, bm, w1c, nd;
    logic        acc;
    int          idx;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_in = '0; m_prev = '0; m_dat = '0; m_ack = 1'b0; m_irq = 1'b0;
      pad_hist.delete();
    end else begin
      ev  = ((m_reg[5] & m_in & ~m_prev) | (~m_reg[5] & ~m_in & m_prev)) & NMASK;
      acc = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
      idx = int'(bus.wb_adr_i[4:2]);
      bm  = {{8{bus.wb_sel_i[3]}}, {8{bus.wb_sel_i[2]}}, {8{bus.wb_sel_i[1]}}, {8{bus.wb_sel_i[0]}}} & NMASK;
      nd  = '0;
      w1c = '0;
      if (acc && !bus.wb_we_i) begin
        if (idx == 2) nd = m_in;
        else if (idx <= 5) nd = m_reg[idx];
      end
      if (acc && bus.wb_we_i) begin
        if (idx == 0 || idx == 1 || idx == 3 || idx == 5)
          m_reg[idx] = (m_reg[idx] & ~bm) | (bus.wb_dat_i & bm);
        else if (idx == 4)
          w1c = bus.wb_dat_i & bm;
      end
      m_reg[4] = (m_reg[4] & ~w1c) | ev;
      m_irq    = |(m_reg[4] & m_reg[3]);
      m_ack    = acc;
      m_dat    = nd;
      m_prev   = m_in;
      pad_hist.push_back(32'(gpio_in));
      if (pad_hist.size() == SYNC_STG) m_in = pad_hist.pop_front();
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("gpio_o", 32'(gpio_out), m_reg[0] & NMASK);
    check("gpio_oe_o", 32'(gpio_oe), m_reg[1] & NMASK);
    check("irq_o", 32'(irq), 32'(m_irq));
    check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
    if (m_ack) check("rdata", bus.wb_dat_o, m_dat);
  end

  task automatic bus_xfer(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, output logic [31:0] r);
    bit got;
    got = 1'b0;
    r   = '0;
    @(negedge clk);
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s; bus.wb_we_i = w;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) begin
        got = 1'b1;
        r   = bus.wb_dat_o;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL bus_timeout adr=0x%02h actual=no_ack expected=ack", a);
    end
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_xfer(a, d, s, 1'b1, dummy);
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] r);
    bus_xfer(a, 32'h0, 4'hF, 1'b0, r);
  endtask

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] r;
    int          n, acks;
    bit          got;

    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_oe", 32'(gpio_oe), 32'h0);
    check("reset_out", 32'(gpio_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_dat", bus.wb_dat_o, 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_rd(5'(a * 4), r);
      check($sformatf("reset_rd_%02h", a * 4), r, 32'h0);
    end

    bus_wr(5'h04, 32'h0000_00FF, 4'hF);
    bus_wr(5'h00, 32'h0000_00A5, 4'hF);
    check("dir_ff", 32'(gpio_oe), 32'h0000_00FF);
    check("out_a5", 32'(gpio_out), 32'h0000_00A5);
    bus_wr(5'h00, 32'h0000_0000, 4'h0);
    bus_rd(5'h00, r);
    check("out_sel0_kept", r, 32'h0000_00A5);
    bus_wr(5'h00, 32'hFFFF_FF5A, 4'h1);
    bus_rd(5'h00, r);
    check("out_lane0_only", r, 32'h0000_005A);
    bus_wr(5'h18, 32'hFFFF_FFFF, 4'hF);
    bus_rd(5'h18, r);
    check("rsvd_18_zero", r, 32'h0);
    check("rsvd_no_side_effect", 32'(gpio_out), 32'h0000_005A);

    @(negedge clk);
    gpio_in = 8'h3C;
    bus_rd(5'h08, r);
    check("in_before_sync", r, 32'h0);
    bus_rd(5'h08, r);
    check("in_after_sync", r, 32'h0000_003C);

    bus_wr(5'h14, 32'h0000_0001, 4'hF);
    bus_wr(5'h0C, 32'h0000_0001, 4'hF);
    @(negedge clk);
    gpio_in = 8'h3D;
    n = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      if (irq) got = 1'b1;
    end
    check("irq_latency", 32'(n), 32'(SYNC_STG + 1));
    @(negedge clk);
    gpio_in = 8'h3C;
    bus_rd(5'h10, r);
    check("istat_set", r, 32'h0000_0001);
    bus_wr(5'h10, 32'h0000_0001, 4'hF);
    bus_rd(5'h10, r);
    check("istat_cleared", r, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    @(negedge clk);
    gpio_in = 8'h3D;
    repeat (SYNC_STG - 1) @(negedge clk);
    bus_wr(5'h10, 32'h0000_0001, 4'hF);
    bus_rd(5'h10, r);
    check("set_beats_clear", r, 32'h0000_0001);
    check("irq_after_race", 32'(irq), 32'h1);
    bus_wr(5'h0C, 32'h0, 4'hF);
    check("irq_ien_off", 32'(irq), 32'h0);
    bus_rd(5'h10, r);
    check("istat_retained", r, 32'h0000_0001);
    @(negedge clk);
    gpio_in = 8'h3C;

    @(negedge clk);
    bus.wb_adr_i = 5'h08; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) acks++;
    end
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    check("held_stb_acks", 32'(acks), 32'd3);

    @(negedge clk);
    bus.wb_adr_i = 5'h00; bus.wb_dat_i = 32'h0000_00FF; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_write_no_ack", 32'(bus.wb_ack_o), 32'h0);
    check("rst_write_discarded", 32'(gpio_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) acks++;
    end
    check("no_ack_after_reset", 32'(acks), 32'h0);
    bus_rd(5'h00, r);
    check("out_after_reset", r, 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
